// File: rtl/demo_timeline.sv
// rtl/demo_timeline.sv - frame-driven demo sequencer with per-state animation outputs
//
// Purpose: steps the demo through INTRO..END one frame at a time and derives
// the animation values (scroller offset, plane start line, sky palette, intro
// flash) for the frame that follows each tick. Every output is a register
// loaded from next-state values, so nothing combinational reaches a pin.
//
// Ports:
//   clk48          single clock
//   rst_n          asynchronous active-low reset
//   frame_tick     one-cycle pulse at the last pixel of each frame
//   songpos        current song row; row 0 late in the timeline restarts it
//   pause          level; freezes the timeline while high
//   skip           one-cycle request to jump to the next state
//   frame          11-bit frame counter
//   state          current state (INTRO=0 .. END=7)
//   state_enter    one-cycle pulse after a tick that changed state
//   scrollh_anim   scroller horizontal offset (mod 4096)
//   plane_y_start  first scanline of the 3D plane
//   sky_idx        sunrise palette base index
//   flash_active   intro white-flash enable
//   flash_level    intro flash brightness
module demo_timeline #(
  parameter int LEN_INTRO     = 100,
  parameter int LEN_TEXT_IN   = 69,
  parameter int LEN_TEXT_HOLD = 40,
  parameter int LEN_PLANE_IN  = 240,
  parameter int LEN_SHOW      = 913,
  parameter int LEN_TEXT_OUT  = 69,
  parameter int LEN_PLANE_OUT = 240
) (
  input  logic        clk48,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic [7:0]  songpos,
  input  logic        pause,
  input  logic        skip,
  output logic [10:0] frame,
  output logic [2:0]  state,
  output logic        state_enter,
  output logic [11:0] scrollh_anim,
  output logic [8:0]  plane_y_start,
  output logic [3:0]  sky_idx,
  output logic        flash_active,
  output logic [5:0]  flash_level
);

  typedef enum logic [2:0] {
    S_INTRO     = 3'd0,
    S_TEXT_IN   = 3'd1,
    S_TEXT_HOLD = 3'd2,
    S_PLANE_IN  = 3'd3,
    S_SHOW      = 3'd4,
    S_TEXT_OUT  = 3'd5,
    S_PLANE_OUT = 3'd6,
    S_END       = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  seg_q, seg_d;
  logic [10:0] frame_q, frame_d;
  logic        pend_q, pend_d;
  logic [5:0]  div_q, div_d;
  logic [3:0]  sky_q, sky_d;
  logic        enter_q, enter_d;
  logic [11:0] scroll_q, scroll_d;
  logic [8:0]  plane_q, plane_d;
  logic        fa_q, fa_d;
  logic [5:0]  fl_q, fl_d;

  logic        advance;
  logic        restart;
  logic [9:0]  len_last;

  // Last seg value of the current state; END never expires.
  always_comb begin
    len_last = '1;
    case (state_q)
      S_INTRO:     len_last = 10'(LEN_INTRO - 1);
      S_TEXT_IN:   len_last = 10'(LEN_TEXT_IN - 1);
      S_TEXT_HOLD: len_last = 10'(LEN_TEXT_HOLD - 1);
      S_PLANE_IN:  len_last = 10'(LEN_PLANE_IN - 1);
      S_SHOW:      len_last = 10'(LEN_SHOW - 1);
      S_TEXT_OUT:  len_last = 10'(LEN_TEXT_OUT - 1);
      S_PLANE_OUT: len_last = 10'(LEN_PLANE_OUT - 1);
      default:     len_last = '1;
    endcase
  end

  always_comb begin
    advance = frame_tick & ~pause;
    // frame>8 keeps the song's own row 0 at start-up from retriggering.
    restart = advance && (frame_q > 11'd8) && (songpos == 8'd0);

    state_d = state_q;
    seg_d   = seg_q;
    frame_d = frame_q;
    div_d   = div_q;
    sky_d   = sky_q;
    // A skip is latched until an advancing tick, so it survives pause.
    pend_d  = pend_q | skip;

    if (advance) begin
      pend_d = 1'b0;
      if (restart) begin
        state_d = S_INTRO;
        seg_d   = '0;
        frame_d = '0;
        div_d   = '0;
        sky_d   = '0;
      end else begin
        frame_d = frame_q + 11'd1;
        if (state_q >= S_TEXT_HOLD) begin
          div_d = div_q + 6'd1;
          if ((div_q == 6'd63) && (sky_q != 4'd15)) begin
            sky_d = sky_q + 4'd1;
          end
        end
        // In END the skip is simply consumed and seg is left alone.
        if (state_q != S_END) begin
          if (skip || pend_q || (seg_q == len_last)) begin
            state_d = state_e'(state_q + 3'd1);
            seg_d   = '0;
          end else begin
            seg_d = seg_q + 10'd1;
          end
        end
      end
    end

    enter_d = advance && (state_d != state_q);

    // Animation outputs are derived from next-state values so they line up
    // with the new frame one cycle after the tick.
    case (state_d)
      S_TEXT_IN:                     scroll_d = 12'd2444 + {seg_d[7:0], 4'b0000};
      S_TEXT_HOLD, S_PLANE_IN, S_SHOW: scroll_d = 12'd3548;
      S_TEXT_OUT:                    scroll_d = 12'd3548 + {seg_d[7:0], 4'b0000};
      default:                       scroll_d = 12'd2048;
    endcase

    case (state_d)
      S_INTRO, S_TEXT_IN, S_TEXT_HOLD: plane_d = 9'd480;
      S_PLANE_IN:                      plane_d = 9'd480 - seg_d[8:0];
      S_SHOW, S_TEXT_OUT:              plane_d = 9'd240;
      S_PLANE_OUT:                     plane_d = 9'd240 - seg_d[8:0];
      default:                         plane_d = 9'd0;
    endcase

    fa_d = (frame_d < 11'd32);
    fl_d = fa_d ? (6'd63 - {frame_d[4:0], 1'b0}) : 6'd0;
  end

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_INTRO;
      seg_q    <= '0;
      frame_q  <= '0;
      pend_q   <= 1'b0;
      div_q    <= '0;
      sky_q    <= '0;
      enter_q  <= 1'b0;
      scroll_q <= 12'd2048;
      plane_q  <= 9'd480;
      fa_q     <= 1'b1;
      fl_q     <= 6'd63;
    end else begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
      pend_q   <= pend_d;
      div_q    <= div_d;
      sky_q    <= sky_d;
      enter_q  <= enter_d;
      scroll_q <= scroll_d;
      plane_q  <= plane_d;
      fa_q     <= fa_d;
      fl_q     <= fl_d;
    end
  end

  assign frame         = frame_q;
  assign state         = state_q;
  assign state_enter   = enter_q;
  assign scrollh_anim  = scroll_q;
  assign plane_y_start = plane_q;
  assign sky_idx       = sky_q;
  assign flash_active  = fa_q;
  assign flash_level   = fl_q;

endmodule

// File: tb/tb_demo_timeline.sv
// tb/tb_demo_timeline.sv - scoreboard bench for demo_timeline
module tb_demo_timeline;

  logic        clk48 = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic [7:0]  songpos;
  logic        pause;
  logic        skip;
  logic [10:0] frame;
  logic [2:0]  state;
  logic        state_enter;
  logic [11:0] scrollh_anim;
  logic [8:0]  plane_y_start;
  logic [3:0]  sky_idx;
  logic        flash_active;
  logic [5:0]  flash_level;

  always #5 clk48 = ~clk48;

  demo_timeline dut (
    .clk48         (clk48),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .songpos       (songpos),
    .pause         (pause),
    .skip          (skip),
    .frame         (frame),
    .state         (state),
    .state_enter   (state_enter),
    .scrollh_anim  (scrollh_anim),
    .plane_y_start (plane_y_start),
    .sky_idx       (sky_idx),
    .flash_active  (flash_active),
    .flash_level   (flash_level)
  );

  typedef struct packed {
    logic [10:0] frame;
    logic [2:0]  state;
    logic        enter;
    logic [11:0] scroll;
    logic [8:0]  plane;
    logic [3:0]  sky;
    logic        fa;
    logic [5:0]  fl;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int n_enter = 0;

  int lens[7] = '{100, 69, 40, 240, 913, 69, 240};
  int m_state, m_seg, m_frame, m_div, m_sky;
  bit m_pend, m_enter;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.frame = 11'(m_frame);
    e.state = 3'(m_state);
    e.enter = m_enter;
    case (m_state)
      1:       e.scroll = 12'((2444 + 16 * m_seg) % 4096);
      2, 3, 4: e.scroll = 12'd3548;
      5:       e.scroll = 12'((3548 + 16 * m_seg) % 4096);
      default: e.scroll = 12'd2048;
    endcase
    case (m_state)
      0, 1, 2: e.plane = 9'd480;
      3:       e.plane = 9'(480 - m_seg);
      4, 5:    e.plane = 9'd240;
      6:       e.plane = 9'(240 - m_seg);
      default: e.plane = 9'd0;
    endcase
    e.sky = 4'(m_sky);
    e.fa  = (m_frame < 32);
    e.fl  = e.fa ? 6'(63 - 2 * (m_frame % 32)) : 6'd0;
    return e;
  endfunction

  task automatic model_reset();
    m_state = 0; m_seg = 0; m_frame = 0; m_div = 0; m_sky = 0;
    m_pend = 0; m_enter = 0;
  endtask

  task automatic model_tick(input bit sk, input bit pz);
    int prev;
    prev = m_state;
    if (sk) m_pend = 1;
    m_enter = 0;
    if (!pz) begin
      if (m_frame > 8 && songpos == 8'd0) begin
        m_state = 0; m_frame = 0; m_seg = 0; m_sky = 0; m_div = 0;
      end else begin
        if (m_state >= 2) begin
          m_div = (m_div + 1) % 64;
          if (m_div == 0 && m_sky < 15) m_sky++;
        end
        m_frame = (m_frame + 1) % 2048;
        if (m_state != 7) begin
          if (m_pend || m_seg == lens[m_state] - 1) begin
            m_state++;
            m_seg = 0;
          end else begin
            m_seg++;
          end
        end
      end
      m_pend  = 0;
      m_enter = (m_state != prev);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", exp_q.size(), 1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("frame",  frame,         e.frame);
    check_eq("state",  state,         e.state);
    check_eq("enter",  state_enter,   e.enter);
    check_eq("scroll", scrollh_anim,  e.scroll);
    check_eq("plane",  plane_y_start, e.plane);
    check_eq("sky",    sky_idx,       e.sky);
    check_eq("fa",     flash_active,  e.fa);
    check_eq("fl",     flash_level,   e.fl);
    if (state_enter === 1'b1) n_enter++;
  endtask

  // Entered and left just after a falling edge.
  task automatic do_tick(input bit sk, input bit pz);
    frame_tick = 1'b1;
    skip       = sk;
    pause      = pz;
    model_tick(sk, pz);
    exp_q.push_back(model_out());
    @(posedge clk48);
    @(negedge clk48);
    frame_tick = 1'b0;
    skip       = 1'b0;
    compare_out();
    @(posedge clk48);
    @(negedge clk48);
    check_eq("enter_one_cycle", state_enter, 0);
    check_eq("frame_stable", frame, m_frame);
  endtask

  task automatic skip_only();
    skip   = 1'b1;
    m_pend = 1;
    @(posedge clk48);
    @(negedge clk48);
    skip = 1'b0;
  endtask

  task automatic check_reset_vals();
    check_eq("rst_frame",  frame,         0);
    check_eq("rst_state",  state,         0);
    check_eq("rst_enter",  state_enter,   0);
    check_eq("rst_scroll", scrollh_anim,  2048);
    check_eq("rst_plane",  plane_y_start, 480);
    check_eq("rst_sky",    sky_idx,       0);
    check_eq("rst_fa",     flash_active,  1);
    check_eq("rst_fl",     flash_level,   63);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; frame_tick = 1'b0; songpos = 8'd1; pause = 1'b0; skip = 1'b0;
    model_reset();
    @(negedge clk48);
    @(negedge clk48);
    check_reset_vals();
    rst_n = 1'b1;
    @(negedge clk48);

    // Free run through the whole timeline.
    for (int i = 0; i < 1671; i++) begin
      do_tick(1'b0, 1'b0);
      if (m_frame == 5)    check_eq("f5_fl", flash_level, 53);
      if (m_frame == 31)   check_eq("f31_fl", flash_level, 1);
      if (m_frame == 32)   check_eq("f32_fa", flash_active, 0);
      if (m_frame == 100)  check_eq("f100_scroll", scrollh_anim, 2444);
      if (m_frame == 101)  check_eq("f101_scroll", scrollh_anim, 2460);
      if (m_frame == 169) begin
        check_eq("f169_state", state, 2);
        check_eq("f169_scroll", scrollh_anim, 3548);
      end
      if (m_frame == 209)  check_eq("f209_plane", plane_y_start, 480);
      if (m_frame == 210)  check_eq("f210_plane", plane_y_start, 479);
      if (m_frame == 1193) check_eq("f1193_sky", sky_idx, 15);
      if (m_frame == 1430) begin
        check_eq("f1430_state", state, 5);
        check_eq("f1430_scroll", scrollh_anim, 540);
      end
    end
    check_eq("end_state", state, 7);
    check_eq("end_frame", frame, 1671);
    check_eq("end_plane", plane_y_start, 0);
    check_eq("enter_count", n_enter, 7);
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b0);
    do_tick(1'b1, 1'b0);
    check_eq("end_skip_state", state, 7);
    check_eq("end_sky_sat", sky_idx, 15);

    // Restart from the middle of SHOW, then no restart at low frames.
    rst_n = 1'b0;
    model_reset();
    @(negedge clk48);
    rst_n = 1'b1;
    @(negedge clk48);
    for (int i = 0; i < 500; i++) do_tick(1'b0, 1'b0);
    songpos = 8'd0;
    do_tick(1'b0, 1'b0);
    check_eq("restart_frame", frame, 0);
    check_eq("restart_state", state, 0);
    check_eq("restart_sky", sky_idx, 0);
    for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b0);
    check_eq("no_restart_f5", frame, 5);
    for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b0);
    check_eq("restart2_frame", frame, 0);
    songpos = 8'd1;

    // Skip held across a pause, then honoured on the first live tick.
    skip_only();
    for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1);
    check_eq("paused_state", state, 0);
    check_eq("paused_frame", frame, 0);
    do_tick(1'b0, 1'b0);
    check_eq("skip_state", state, 1);
    check_eq("skip_scroll", scrollh_anim, 2444);
    do_tick(1'b1, 1'b0);
    check_eq("sameskip_state", state, 2);
    do_tick(1'b1, 1'b0);
    check_eq("plane_in_state", state, 3);
    for (int i = 0; i < 5; i++) do_tick(1'b0, 1'b0);
    check_eq("plane_in_plane", plane_y_start, 475);

    // Reset mid-frame with a skip pending.
    skip_only();
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    @(negedge clk48);
    @(negedge clk48);
    rst_n = 1'b1;
    @(negedge clk48);
    do_tick(1'b0, 1'b0);
    check_eq("post_rst_frame", frame, 1);
    check_eq("post_rst_state", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demo_timeline.md
DEMO_TIMELINE -- requirements
Module: demo_timeline

Interface
REQ-001 SHALL have parameter LEN_INTRO, default 100, frames in INTRO.
REQ-002 SHALL have parameter LEN_TEXT_IN, default 69, frames in TEXT_IN.
REQ-003 SHALL have parameter LEN_TEXT_HOLD, default 40, frames in TEXT_HOLD.
REQ-004 SHALL have parameter LEN_PLANE_IN, default 240, frames in PLANE_IN.
REQ-005 SHALL have parameter LEN_SHOW, default 913, frames in SHOW.
REQ-006 SHALL have parameter LEN_TEXT_OUT, default 69, frames in TEXT_OUT.
REQ-007 SHALL have parameter LEN_PLANE_OUT, default 240, frames in PLANE_OUT.
REQ-008 SHALL have port clk48, input, 1, the single clock.
REQ-009 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-010 SHALL have port frame_tick, input, 1, one-cycle pulse at the last pixel of each frame.
REQ-011 SHALL have port songpos, input, 8, current song row from the audio track.
REQ-012 SHALL have port pause, input, 1, level; freezes the timeline.
REQ-013 SHALL have port skip, input, 1, one-cycle request to jump to the next state.
REQ-014 SHALL have port frame, output, 11, frame counter.
REQ-015 SHALL have port state, output, 3, encoded as INTRO=0, TEXT_IN=1, TEXT_HOLD=2, PLANE_IN=3, SHOW=4, TEXT_OUT=5, PLANE_OUT=6, END=7.
REQ-016 SHALL have port state_enter, output, 1, one-cycle pulse on any state change.
REQ-017 SHALL have port scrollh_anim, output, 12, scroller horizontal offset.
REQ-018 SHALL have port plane_y_start, output, 9, first scanline of the 3D plane.
REQ-019 SHALL have port sky_idx, output, 4, sunrise palette base index.
REQ-020 SHALL have port flash_active, output, 1, intro white-flash enable.
REQ-021 SHALL have port flash_level, output, 6, intro flash brightness.

Function
REQ-022 SHALL keep all state in registers clocked on clk48; the timeline advances only on cycles with frame_tick=1 and pause=0.
REQ-023 SHALL keep an internal segment counter seg (10 bits) that counts frames within the current state.
REQ-024 On an advancing tick, if seg==LEN_cur-1, state SHALL go to the next state with seg=0; otherwise seg SHALL increment.
REQ-025 END SHALL have no length and SHALL hold until a restart.
REQ-026 On each advancing tick, frame SHALL increment modulo 2048.
REQ-027 Restart: on an advancing tick with frame>8 and songpos==0, the block SHALL set state=INTRO, frame=0, seg=0, sky_idx=0 and clear the sky divider.
REQ-028 A skip pulse SHALL set a pending flag that persists through pause; the next advancing tick SHALL force the next state with seg=0 and clear the flag.
REQ-029 A skip while in END SHALL be consumed with no state change.
REQ-030 Precedence at a tick SHALL be restart > pending skip > normal advance; a skip arriving on the same cycle as a tick SHALL be honoured at that tick.
REQ-031 scrollh_anim (modulo 4096) SHALL be: 2048 in INTRO, PLANE_OUT and END; 2444+16*seg in TEXT_IN; 3548 in TEXT_HOLD, PLANE_IN and SHOW; 3548+16*seg in TEXT_OUT (wrap permitted, e.g. seg 68 gives 540).
REQ-032 plane_y_start SHALL be: 480 in INTRO through TEXT_HOLD; 480-seg in PLANE_IN; 240 in SHOW and TEXT_OUT; 240-seg in PLANE_OUT; 0 in END.
REQ-033 Sky divider (6 bits): on each advancing tick while state is in TEXT_HOLD..END, the divider SHALL increment; on wrap 63->0, sky_idx SHALL increment, saturating at 15.
REQ-034 sky_idx SHALL be 0 in INTRO and TEXT_IN.
REQ-035 flash_active SHALL equal (frame<32); flash_level SHALL equal 63-2*frame[4:0] while active, else 0.
REQ-036 scrollh_anim, plane_y_start, sky_idx, flash_active and flash_level SHALL be valid on the cycle after the tick edge and stable for the rest of the frame (zero combinational input-to-output paths).
REQ-037 state_enter SHALL be high for exactly one cycle, the cycle after a tick that changes state, including restart from a state other than INTRO.

Reset
REQ-038 While rst_n=0, the block SHALL asynchronously force frame=0, state=INTRO, seg=0, pending skip=0, sky divider=0, sky_idx=0, state_enter=0, scrollh_anim=2048, plane_y_start=480, flash_active=1, flash_level=63.
REQ-039 A reset asserted mid-frame SHALL discard any pending skip; the first tick after release SHALL produce frame=1.

Verification
REQ-040 Free-run 1671 ticks with songpos=1 -> state=END, frame=1671, plane_y_start=0; state_enter seen 7 times; at frame 209, plane_y_start=480; at frame 210, plane_y_start=479.
REQ-041 Run to frame 100 then 101 -> scrollh_anim=2444, then 2460; at frame 169 state=TEXT_HOLD and scrollh_anim=3548.
REQ-042 Set songpos=0 at frame 500 -> next tick gives frame=0, state=INTRO, sky_idx=0, state_enter pulse; songpos=0 at frame 5 -> no restart.
REQ-043 Skip pulse with pause=1 held across 3 ticks -> no change; pause released -> next tick moves to the next state, seg=0.
REQ-044 Ticks continue to frame 1193 (sky_idx 15) and beyond -> sky_idx stays at 15; TEXT_OUT seg 68 -> scrollh_anim=540.
REQ-045 Assert rst_n=0 mid-PLANE_IN with skip pending -> outputs take reset values immediately; after release, one tick gives frame=1 with state=INTRO.
